// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator:
//   - counter width and the upper bound on any axis total
//   - default 640x480@60 timing constants (pixels / lines)
//   - derived default H_TOTAL / V_TOTAL
//   - phase encoding shared by the horizontal and vertical axis FSMs
//     (PH_ACT/PH_FRONT/PH_SYNC/PH_BACK play the role of H_ACT..H_BACK on the
//     horizontal axis and V_ACT..V_BACK on the vertical axis; generic names
//     avoid clashing with the H_SYNC/V_SYNC timing parameters)
// -----------------------------------------------------------------------------
package vga_pkg;

  // Both axis counters are 10-bit unsigned, so a total may not exceed 1024.
  localparam int CNT_W      = 10;
  localparam int MAX_TOTAL  = 1024;

  // Prescaler width used when the pixel strobe is divided down from clk.
  localparam int PRESCALE_W = 2;

  // Default horizontal timing, in pixels.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default vertical timing, in lines.
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Total length of one axis period (visible + porches + sync).
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Phase of one axis within its period.
  typedef enum logic [1:0] {
    PH_ACT   = 2'd0,
    PH_FRONT = 2'd1,
    PH_SYNC  = 2'd2,
    PH_BACK  = 2'd3
  } axis_phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One timing axis (horizontal or vertical): a wrapping position counter plus
// a four-phase FSM (active, front porch, sync, back porch). The sync output is
// registered from the same next-count value that loads the counter, so it
// lines up with o_count in the same cycle (zero relative latency).
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   i_en          in   update strobe (one per pixel); nothing changes without it
//   i_restart     in   with i_en: load position 0 / active phase
//   i_step        in   with i_en: advance the position by one (wraps)
//   o_count       out  current position (registered)
//   o_wrap        out  position is the last one of the period
//   o_sync_n      out  registered sync, active-low, aligned with o_count
//   o_next_active out  position about to be loaded is inside the visible area
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_restart,
  input  logic             i_step,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap,
  output logic             o_sync_n,
  output logic             o_next_active
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // Phase boundaries expressed as counter values.
  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] r_count;
  axis_phase_e      r_state;
  logic             r_sync_n;
  logic [CNT_W-1:0] w_next_count;

  // Position that will be loaded on the next enabled edge.
  always_comb begin
    w_next_count = r_count;
    if (i_restart) begin
      w_next_count = ZERO;
    end else if (i_step) begin
      if (r_count == LAST) begin
        w_next_count = ZERO;
      end else begin
        w_next_count = r_count + ONE;
      end
    end else begin
      w_next_count = r_count;
    end
  end

  // Counter and phase FSM; sync is decoded from the phase being entered so
  // it changes on the same edge as the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= ZERO;
      r_state  <= PH_ACT;
      r_sync_n <= 1'b1;
    end else if (i_en) begin
      r_count <= w_next_count;
      if (i_restart) begin
        r_state  <= PH_ACT;
        r_sync_n <= 1'b1;
      end else begin
        case (r_state)
          PH_ACT: begin
            if (w_next_count == FRONT_AT) begin
              r_state  <= PH_FRONT;
              r_sync_n <= 1'b1;
            end else begin
              r_state  <= PH_ACT;
              r_sync_n <= 1'b1;
            end
          end
          PH_FRONT: begin
            if (w_next_count == SYNC_AT) begin
              r_state  <= PH_SYNC;
              r_sync_n <= 1'b0;
            end else begin
              r_state  <= PH_FRONT;
              r_sync_n <= 1'b1;
            end
          end
          PH_SYNC: begin
            if (w_next_count == BACK_AT) begin
              r_state  <= PH_BACK;
              r_sync_n <= 1'b1;
            end else begin
              r_state  <= PH_SYNC;
              r_sync_n <= 1'b0;
            end
          end
          PH_BACK: begin
            if (w_next_count == ZERO) begin
              r_state  <= PH_ACT;
              r_sync_n <= 1'b1;
            end else begin
              r_state  <= PH_BACK;
              r_sync_n <= 1'b1;
            end
          end
          default: begin
            r_state  <= PH_ACT;
            r_sync_n <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_count       = r_count;
  assign o_sync_n      = r_sync_n;
  assign o_wrap        = (r_count == LAST);
  assign o_next_active = (w_next_count < FRONT_AT);

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator. Two vga_axis_counter instances produce the
// horizontal and vertical positions, phases and syncs; this level owns the
// pixel strobe, the "first pixel after reset" restart and the combined
// video_on / frame_start flags.
//
// Every output changes together on the edge that raises pix_en, so a cycle
// with pix_en high always presents a fresh pixel and all flags describe the
// h_count/v_count shown in that same cycle. The first strobe after reset
// presents (0,0) with video_on=1 and frame_start=1 instead of advancing.
//
// Optional feature (macro VGA_TIMING_PRESCALE_EN):
//   defined   - pix_en is high one clk in every 4 (2-bit prescaler)
//   undefined - every clk is a pixel; no prescaler is built
//
// Ports:
//   clk          in   system clock (100 MHz), rising edge
//   rst_n        in   asynchronous active-low reset
//   pix_en       out  pixel strobe, one clk wide
//   h_count[9:0] out  pixel column 0..H_TOTAL-1
//   v_count[9:0] out  line 0..V_TOTAL-1
//   video_on     out  visible-area flag
//   h_sync       out  horizontal sync, active-low
//   v_sync       out  vertical sync, active-low
//   frame_start  out  high while pixel (0,0) is presented
// H_TOTAL and V_TOTAL must each be at most 1024 (10-bit counters).
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             video_on,
  output logic             h_sync,
  output logic             v_sync,
  output logic             frame_start
);

  logic w_stb;
  logic w_restart;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_h_next_active;
  logic w_v_next_active;

  logic r_pix_en;
  logic r_started;
  logic r_video_on;
  logic r_frame_start;

`ifdef VGA_TIMING_PRESCALE_EN
  localparam logic [PRESCALE_W-1:0] PRESC_LAST = {PRESCALE_W{1'b1}};
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] r_presc;

  // Free-running divide-by-4 prescaler; the strobe fires on its last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= {PRESCALE_W{1'b0}};
    end else begin
      r_presc <= r_presc + PRESC_ONE;
    end
  end

  assign w_stb = (r_presc == PRESC_LAST);
`else
  assign w_stb = 1'b1;
`endif

  // Until the first strobe after reset, the next pixel is a restart at (0,0)
  // rather than an advance.
  assign w_restart = ~r_started;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (w_stb),
    .i_restart     (w_restart),
    .i_step        (1'b1),
    .o_count       (h_count),
    .o_wrap        (w_h_wrap),
    .o_sync_n      (h_sync),
    .o_next_active (w_h_next_active)
  );

  // The vertical axis only steps on the pixel where the line wraps.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (w_stb),
    .i_restart     (w_restart),
    .i_step        (w_h_wrap),
    .o_count       (v_count),
    .o_wrap        (w_v_wrap),
    .o_sync_n      (v_sync),
    .o_next_active (w_v_next_active)
  );

  // Pixel strobe register; held low in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_en <= 1'b0;
    end else begin
      r_pix_en <= w_stb;
    end
  end

  // Combined pixel flags, loaded alongside the axis counters. The next pixel
  // is (0,0) either on restart or when both axes sit on their last position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started     <= 1'b0;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_stb) begin
      r_started     <= 1'b1;
      r_video_on    <= w_h_next_active & w_v_next_active;
      r_frame_start <= w_restart | (w_h_wrap & w_v_wrap);
    end
  end

  assign pix_en      = r_pix_en;
  assign video_on    = r_video_on;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PRESCALE_EN
  localparam int PIX_DIV = 4;
`else
  localparam int PIX_DIV = 1;
`endif

  // Reduced raster for whole-frame checks: 16 pixels x 11 lines.
  localparam int SH_TOT = 16;
  localparam int SV_TOT = 11;
  localparam int S_FRAME = SH_TOT * SV_TOT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n_a, rst_n_b;
  logic       pe_a, von_a, hs_a, vs_a, fs_a;
  logic [9:0] h_a, v_a;
  logic       pe_b, von_b, hs_b, vs_b, fs_b;
  logic [9:0] h_b, v_b;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .pix_en(pe_a), .h_count(h_a), .v_count(v_a),
    .video_on(von_a), .h_sync(hs_a), .v_sync(vs_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .pix_en(pe_b), .h_count(h_b), .v_count(v_b),
    .video_on(von_b), .h_sync(hs_b), .v_sync(vs_b), .frame_start(fs_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) for the next cycle with pix_en high; gap = clk cycles waited.
  task automatic next_pix(input bit use_b, output int gap);
    logic pe;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      pe = use_b ? pe_b : pe_a;
    end while (pe !== 1'b1 && gap < 16);
    if (pe !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL pix_en_timeout: got no strobe in %0d clk, expected one within %0d", gap, PIX_DIV);
    end
  endtask

  typedef struct {
    int idx;
    int h;
    int v;
    bit hs;
    bit vs;
    bit von;
    bit fs;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int p, gap, gmin, gmax, t0, t800, hs_low0, von0, fs_extra;
    int eh, ev, vs_low_f0, von_f0, last_fs;
    bit ehs, evs, evon, efs;

    // Default 800x525 raster, pixel index after reset -> expected outputs.
    vecs[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{640,  640, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{655,  655, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{656,  656, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{751,  751, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{752,  752, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{799,  799, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1439, 639, 1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1440, 640, 1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_h_count", 32'(h_a), 32'd0);
    check("rst_v_count", 32'(v_a), 32'd0);
    check("rst_h_sync", 32'(hs_a), 32'd1);
    check("rst_v_sync", 32'(vs_a), 32'd1);
    check("rst_video_on", 32'(von_a), 32'd0);
    check("rst_frame_start", 32'(fs_a), 32'd0);
    check("rst_pix_en", 32'(pe_a), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_hold_pix_en", 32'(pe_a), 32'd0);

    // ---------------- default raster: table-driven line checks ----------------
    rst_n_a = 1'b1;
    p = -1; gmin = 1000; gmax = 0; t0 = 0; t800 = 0;
    hs_low0 = 0; von0 = 0; fs_extra = 0;
    for (int k = 0; k < 12; k++) begin
      while (p < vecs[k].idx) begin
        next_pix(1'b0, gap);
        p++;
        if (p > 0) begin
          if (gap < gmin) gmin = gap;
          if (gap > gmax) gmax = gap;
          if (fs_a === 1'b1) fs_extra++;
        end
        if (p == 0) t0 = cyc;
        if (p == 800) t800 = cyc;
        if (p < 800 && hs_a === 1'b0) hs_low0++;
        if (p < 800 && von_a === 1'b1) von0++;
      end
      check("vec_h_count", 32'(h_a), 32'(vecs[k].h));
      check("vec_v_count", 32'(v_a), 32'(vecs[k].v));
      check("vec_h_sync", 32'(hs_a), 32'(vecs[k].hs));
      check("vec_v_sync", 32'(vs_a), 32'(vecs[k].vs));
      check("vec_video_on", 32'(von_a), 32'(vecs[k].von));
      check("vec_frame_start", 32'(fs_a), 32'(vecs[k].fs));
    end
    check("pix_en_gap_min", 32'(gmin), 32'(PIX_DIV));
    check("pix_en_gap_max", 32'(gmax), 32'(PIX_DIV));
    check("h_period_clk", 32'(t800 - t0), 32'(800 * PIX_DIV));
    check("h_sync_low_pixels", 32'(hs_low0), 32'd96);
    check("video_on_line0_pixels", 32'(von0), 32'd640);
    check("frame_start_extra", 32'(fs_extra), 32'd0);

    // ---------------- mid-line reset on the default raster ----------------
    while (p < 800 + 700) begin
      next_pix(1'b0, gap);
      p++;
    end
    check("pre_rst_h_count", 32'(h_a), 32'd700);
    check("pre_rst_h_sync", 32'(hs_a), 32'd0);
    #1 rst_n_a = 1'b0;
    #1;
    check("async_rst_h_count", 32'(h_a), 32'd0);
    check("async_rst_v_count", 32'(v_a), 32'd0);
    check("async_rst_h_sync", 32'(hs_a), 32'd1);
    check("async_rst_video_on", 32'(von_a), 32'd0);
    check("async_rst_pix_en", 32'(pe_a), 32'd0);
    @(negedge clk);
    rst_n_a = 1'b1;
    next_pix(1'b0, gap);
    check("restart_h_count", 32'(h_a), 32'd0);
    check("restart_v_count", 32'(v_a), 32'd0);
    check("restart_frame_start", 32'(fs_a), 32'd1);
    check("restart_video_on", 32'(von_a), 32'd1);
    rst_n_a = 1'b0;

    // ---------------- reduced raster: whole frames against a model ----------------
    check("b_rst_h_sync", 32'(hs_b), 32'd1);
    check("b_rst_v_sync", 32'(vs_b), 32'd1);
    rst_n_b = 1'b1;
    vs_low_f0 = 0; von_f0 = 0; last_fs = -1;
    // Stop at (h=11, v=4) of the third frame: inside horizontal sync.
    for (int q = 0; q <= 2 * S_FRAME + 4 * SH_TOT + 11; q++) begin
      next_pix(1'b1, gap);
      eh   = q % SH_TOT;
      ev   = (q / SH_TOT) % SV_TOT;
      ehs  = !(eh >= 10 && eh < 13);
      evs  = !(ev >= 7 && ev < 9);
      evon = (eh < 8) && (ev < 6);
      efs  = (eh == 0) && (ev == 0);
      check("b_h_count", 32'(h_b), 32'(eh));
      check("b_v_count", 32'(v_b), 32'(ev));
      check("b_h_sync", 32'(hs_b), 32'(ehs));
      check("b_v_sync", 32'(vs_b), 32'(evs));
      check("b_video_on", 32'(von_b), 32'(evon));
      check("b_frame_start", 32'(fs_b), 32'(efs));
      if (q < S_FRAME && vs_b === 1'b0) vs_low_f0++;
      if (q < S_FRAME && von_b === 1'b1) von_f0++;
      if (fs_b === 1'b1) begin
        if (last_fs >= 0) check("b_frame_period", 32'(q - last_fs), 32'(S_FRAME));
        last_fs = q;
      end
    end
    check("b_v_sync_low_pixels", 32'(vs_low_f0), 32'(2 * SH_TOT));
    check("b_video_on_pixels", 32'(von_f0), 32'd48);

    // Mid-frame reset on the reduced raster while h_sync is low.
    #1 rst_n_b = 1'b0;
    #1;
    check("b_async_rst_h_count", 32'(h_b), 32'd0);
    check("b_async_rst_v_count", 32'(v_b), 32'd0);
    check("b_async_rst_h_sync", 32'(hs_b), 32'd1);
    check("b_async_rst_frame_start", 32'(fs_b), 32'd0);
    @(negedge clk);
    rst_n_b = 1'b1;
    next_pix(1'b1, gap);
    check("b_restart_h_count", 32'(h_b), 32'd0);
    check("b_restart_v_count", 32'(v_b), 32'd0);
    check("b_restart_frame_start", 32'(fs_b), 32'd1);
    next_pix(1'b1, gap);
    check("b_second_h_count", 32'(h_b), 32'd1);
    check("b_second_frame_start", 32'(fs_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 SHALL have parameters V_FP, 10; V_SYNC, 2; V_BP, 33; vertical porch and sync widths in lines.
REQ-007 SHALL have port clk  in  1  system clock, 100 MHz; sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port pix_en  out  1  pixel strobe, one clk wide.
REQ-010 SHALL have port h_count  out  10  current pixel column, 0..799.
REQ-011 SHALL have port v_count  out  10  current line, 0..524.
REQ-012 SHALL have port video_on  out  1  high when h_count < H_ACTIVE and v_count < V_ACTIVE.
REQ-013 SHALL have port h_sync  out  1  horizontal sync, active-low.
REQ-014 SHALL have port v_sync  out  1  vertical sync, active-low.
REQ-015 SHALL have port frame_start  out  1  one-pix_en-period pulse at pixel (0,0).

Function
REQ-016 SHALL advance all counters and outputs only on clk edges where pix_en is high.
REQ-017 SHALL increment h_count by 1 each pixel and wrap from H_TOTAL-1 (799) to 0.
REQ-018 SHALL increment v_count only when h_count wraps, and wrap v_count from V_TOTAL-1 (524) to 0 on the same edge as h_count wraps.
REQ-019 SHALL implement a horizontal FSM with states H_ACT, H_FRONT, H_SYNC, H_BACK:
- H_ACT->H_FRONT at h_count=H_ACTIVE
- H_FRONT->H_SYNC at H_ACTIVE+H_FP
- H_SYNC->H_BACK at H_ACTIVE+H_FP+H_SYNC
- H_BACK->H_ACT at wrap
REQ-020 SHALL implement a vertical FSM with states V_ACT, V_FRONT, V_SYNC, V_BACK, with the same boundaries on v_count; it transitions only on h_count wrap.
REQ-021 SHALL register h_sync, v_sync and video_on so they correspond to the h_count/v_count values presented in the same cycle; there is zero relative latency.
REQ-022 SHALL drive h_sync low exactly while h_count is in 656..751 and v_sync low exactly while v_count is in 490..491, under default parameters.
REQ-023 SHALL assert frame_start while h_count=0 and v_count=0, deasserting on the next pix_en.
REQ-024 SHALL use 10-bit unsigned counters; H_TOTAL and V_TOTAL SHALL each not exceed 1024.

Reset
REQ-025 SHALL, while rst_n is low, hold h_count=0, v_count=0, h_sync=1, v_sync=1, video_on=0, frame_start=0, pix_en=0, prescaler=0, and both FSMs in *_ACT.
REQ-026 SHALL, when rst_n asserts mid-line or mid-frame, abandon the frame immediately without completing the line.
REQ-027 SHALL present the first pixel (0,0) with video_on=1 and frame_start=1 on the first pix_en after reset release.

Configuration
REQ-028 SHALL, with VGA_TIMING_PRESCALE_EN defined, generate pix_en from a 2-bit prescaler, high one clk in every 4, giving 25 MHz pixel rate.
REQ-029 SHALL, without VGA_TIMING_PRESCALE_EN, tie pix_en high (every clk is a pixel) and omit the prescaler.

Structure
REQ-030 SHALL place the default timing constants, H_TOTAL/V_TOTAL derivations and FSM state encodings in shared package vga_pkg.
REQ-031 SHALL use one sub-module, vga_axis_counter, instantiated twice (horizontal and vertical): a counter plus phase FSM with enable, wrap output and sync/active decode.

Verification
REQ-032 SHALL verify with PRESCALE_EN, from reset: pix_en period = 4 clk; h_count period = 3200 clk.
REQ-033 SHALL verify h_sync falls at h_count=656 and rises at h_count=752, giving 96 pixels low per line.
REQ-034 SHALL verify v_sync is low for exactly 2 lines (v_count 490,491) and frame_start occurs every 420000 pixels.
REQ-035 SHALL verify video_on is high for exactly 307200 pixels per frame and is low for h_count in 640..799.
REQ-036 SHALL verify that pulsing rst_n low at h_count=300, v_count=200 gives h_count=0, v_count=0, h_sync=1 immediately, with (0,0) frame_start=1 on the first pix_en after release.
REQ-037 SHALL verify without PRESCALE_EN: pix_en is constantly 1 and h_count period = 800 clk.
